bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/ser_pkg.sv | 16 +
 rtl/ser_fifo.sv | 66 ++++++
 rtl/bit_serializer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared definitions for the bit_serializer slice.
//   ser_state_t        - serializer FSM state encoding
//   SER_DATA_W_DEF     - default word width in bits
//   SER_FIFO_DEPTH_DEF - default input buffer depth in entries
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_t;

    localparam int unsigned SER_DATA_W_DEF     = 8;
    localparam int unsigned SER_FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous FIFO used as the serializer input buffer.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset (empties the buffer)
//   i_push   - write i_din this edge (ignored when full)
//   i_din    - write data
//   i_pop    - advance the read pointer this edge (ignored when empty)
//   o_head   - word at the read pointer
//   o_level  - number of stored words, 0..DEPTH
//   o_full   - level == DEPTH
//   o_empty  - level == 0
module ser_fifo
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W = SER_DATA_W_DEF,
    parameter int unsigned DEPTH  = SER_FIFO_DEPTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic [DATA_W-1:0]       i_din,
    input  logic                    i_pop,
    output logic [DATA_W-1:0]       o_head,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Pointers are AW bits wide with DEPTH a power of two, so they wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: buffers parallel words and shifts them out MSB first.
// Optional feature: define SER_PARITY_EN to append an even-parity bit
// (XOR of the data bits) to every frame; ser_last then marks the parity bit.
// Ports:
//   sys_clk    - clock, rising edge
//   sys_rst    - asynchronous active-high reset
//   din        - parallel input word
//   din_valid  - din is offered this cycle
//   din_ready  - buffer accepts a word this cycle
//   ser_out    - serial data bit (0 when ser_valid is 0)
//   ser_valid  - ser_out carries a frame bit
//   ser_last   - current bit ends its frame (0 when ser_valid is 0)
//   fifo_level - number of buffered words
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W     = SER_DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = SER_FIFO_DEPTH_DEF
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [DATA_W-1:0]            din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic                         ser_out,
    output logic                         ser_valid,
    output logic                         ser_last,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned     CNT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    ser_state_t        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ser_out;
    logic              r_ser_valid;
    logic              r_ser_last;
    logic              r_rdy_en;
`ifdef SER_PARITY_EN
    logic              r_par;
`endif

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_shift_nxt;

    // r_rdy_en holds din_ready low through reset and releases it on the first edge after.
    assign din_ready   = r_rdy_en && !w_full;
    assign w_push      = din_valid && din_ready;
    assign w_shift_nxt = r_shift << 1;

`ifdef SER_PARITY_EN
    assign w_frame_end = (r_state == ST_PARITY);
`else
    assign w_frame_end = (r_state == ST_SHIFT) && (r_cnt == '0);
`endif

    // Pop from idle, or on the final bit so the next frame follows without a gap.
    assign w_pop = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;

    ser_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_push  (w_push),
        .i_din   (din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // r_cnt counts the data bits still to follow the one currently on ser_out.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_rdy_en    <= 1'b0;
`ifdef SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_rdy_en <= 1'b1;
            if (w_pop) begin
                r_state     <= ST_SHIFT;
                r_shift     <= w_head;
                r_cnt       <= CNT_MAX;
                r_ser_out   <= w_head[DATA_W-1];
                r_ser_valid <= 1'b1;
                r_ser_last  <= 1'b0;
`ifdef SER_PARITY_EN
                r_par       <= ^w_head;
`endif
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (r_cnt != '0) begin
                            r_shift   <= w_shift_nxt;
                            r_ser_out <= w_shift_nxt[DATA_W-1];
                            r_cnt     <= r_cnt - 1'b1;
`ifdef SER_PARITY_EN
                            r_ser_last <= 1'b0;
`else
                            r_ser_last <= (r_cnt == CNT_W'(1));
`endif
                        end else begin
`ifdef SER_PARITY_EN
                            r_state    <= ST_PARITY;
                            r_ser_out  <= r_par;
                            r_ser_last <= 1'b1;
`else
                            r_state     <= ST_IDLE;
                            r_ser_out   <= 1'b0;
                            r_ser_valid <= 1'b0;
                            r_ser_last  <= 1'b0;
`endif
                        end
                    end
                    // IDLE with an empty buffer, or a finished parity bit with nothing queued.
                    default: begin
                        r_state     <= ST_IDLE;
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_ser_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
